alu_seq: RTL



---
 rtl/alu_seq_if.sv | 30 +++
 rtl/alu_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle for alu_seq. Rev 1.0
`default_nettype none

interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op_code;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             carry_flag;
  logic             overflow_flag;

  modport master (
    output in_valid, a, b, op_code, out_ready,
    input  in_ready, out_valid, result, zero_flag, carry_flag, overflow_flag
  );

  modport slave (
    input  in_valid, a, b, op_code, out_ready,
    output in_ready, out_valid, result, zero_flag, carry_flag, overflow_flag
  );
endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with iterative multiply and unsigned divide. Rev 1.0
`default_nettype none

module alu_seq #(
  parameter int WIDTH = 16
) (
  input  wire logic    clk,
  input  wire logic    rst,
  alu_seq_if.slave     bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_SAR   = 4'd8;
  localparam logic [3:0] OP_CMPEQ = 4'd9;
  localparam logic [3:0] OP_CMPLT = 4'd10;
  localparam logic [3:0] OP_CMPLE = 4'd11;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_iop;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;

  logic             w_accept;
  logic             w_iter;
  logic             w_last;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH:0]   w_sar;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;
  logic [WIDTH:0]   w_madd;
  logic [WIDTH:0]   w_dshift;
  logic             w_dge;
  logic [WIDTH-1:0] w_dsub;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic [WIDTH-1:0] w_it_res;
  logic             w_it_c;
  logic             w_it_v;

  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_iter   = (bus.op_code[3:2] == 2'b11);
  assign w_last   = (r_cnt == CW'(1));
  assign w_sh     = bus.b[SHW-1:0];

  // Extra bit on each shift captures the last bit shifted out
  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};
  assign w_shl  = {1'b0, bus.a} << w_sh;
  assign w_shr  = {bus.a, 1'b0} >> w_sh;
  assign w_sar  = $signed({bus.a, 1'b0}) >>> w_sh;

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (bus.op_code)
      OP_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_c   = w_diff[WIDTH];
        w_alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: w_alu_res = bus.a & bus.b;
      OP_OR:  w_alu_res = bus.a | bus.b;
      OP_XOR: w_alu_res = bus.a ^ bus.b;
      OP_NOT: w_alu_res = ~bus.a;
      OP_SHL: begin
        w_alu_res = w_shl[WIDTH-1:0];
        w_alu_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_alu_res = w_shr[WIDTH:1];
        w_alu_c   = w_shr[0];
      end
      OP_SAR: begin
        w_alu_res = w_sar[WIDTH:1];
        w_alu_c   = w_sar[0];
      end
      OP_CMPEQ: w_alu_res = WIDTH'(bus.a == bus.b);
      OP_CMPLT: w_alu_res = WIDTH'($signed(bus.a) < $signed(bus.b));
      OP_CMPLE: w_alu_res = WIDTH'($signed(bus.a) <= $signed(bus.b));
      default: ;
    endcase
  end

  // Multiply: {hi,lo} starts as {0,b}; add a into hi when lo[0] set, shift right.
  // Divide: lo starts as dividend; restoring step into hi; zero divisor yields all-ones quotient.
  assign w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_dshift = {r_hi, r_lo[WIDTH-1]};
  assign w_dge    = (w_dshift >= {1'b0, r_opnd});
  assign w_dsub   = w_dshift[WIDTH-1:0] - r_opnd;

  always_comb begin
    if (r_iop[1]) begin
      w_step_hi = w_dge ? w_dsub : w_dshift[WIDTH-1:0];
      w_step_lo = {r_lo[WIDTH-2:0], w_dge};
    end else begin
      w_step_hi = w_madd[WIDTH:1];
      w_step_lo = {w_madd[0], r_lo[WIDTH-1:1]};
    end
  end

  assign w_it_res = r_iop[0] ? w_step_hi : w_step_lo;
  assign w_it_c   = !r_iop[1] && (w_step_hi != '0);
  assign w_it_v   = r_iop[1] && (r_opnd == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_iter ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last) w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == S_IDLE);
    bus.out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_iop    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_accept && w_iter) begin
        r_iop  <= bus.op_code[1:0];
        r_cnt  <= CW'(WIDTH);
        r_hi   <= '0;
        r_lo   <= bus.op_code[1] ? bus.a : bus.b;
        r_opnd <= bus.op_code[1] ? bus.b : bus.a;
      end else if (w_accept) begin
        r_result <= w_alu_res;
        r_zero   <= (w_alu_res == '0);
        r_carry  <= w_alu_c;
        r_ovf    <= w_alu_v;
      end
    end else if (r_state == S_BUSY) begin
      r_hi  <= w_step_hi;
      r_lo  <= w_step_lo;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_result <= w_it_res;
        r_zero   <= (w_it_res == '0);
        r_carry  <= w_it_c;
        r_ovf    <= w_it_v;
      end
    end
  end

  assign bus.result        = r_result;
  assign bus.zero_flag     = r_zero;
  assign bus.carry_flag    = r_carry;
  assign bus.overflow_flag = r_ovf;

endmodule

`default_nettype wire
